// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter for the execute stage.
// Performs SLL, SRL, SRA and ROTR by a variable amount. The log2(WIDTH)
// shift levels are spread over STAGES register stages; a valid/ready
// handshake moves each operation, together with its tag, through the
// stages. The pipeline can be stalled by the consumer or flushed.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   flush      synchronous kill of every in-flight operation
//   in_valid   request present
//   in_ready   unit accepts a request this cycle (combinational)
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   in_tag     opaque tag, returned unchanged with the result
//   out_valid  result present (registered)
//   out_ready  consumer accepts the result
//   out_data   shifted result (registered)
//   out_tag    tag of the result (registered)

module pipe_shifter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRL  = 2'b01;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  localparam logic [WIDTH-1:0] ONES = '1;

  // Register stage that owns shift level lvl.
  function automatic int unsigned stage_of(input int unsigned lvl);
    return (lvl * STAGES) / SHAMT_W;
  endfunction

  // One shift level: move the data by 2^lvl positions in the given mode.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int unsigned      lvl
  );
    int unsigned k;
    k = 32'd1 << lvl;
    case (mode)
      MODE_SLL: shift_level = d << k;
      MODE_SRL: shift_level = d >> k;
      // Fill uses the sign latched from the original operand, never from
      // partially shifted data.
      MODE_SRA: shift_level = (d >> k) | (sign ? ~(ONES >> k) : '0);
      default:  shift_level = (d >> k) | (d << (WIDTH - k));
    endcase
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned S = s;

    logic               src_valid;
    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [1:0]         src_mode;
    logic               src_sign;
    logic [TAG_W-1:0]   src_tag;

    logic               next_ready;
    logic               ready;
    logic               load;
    logic [WIDTH-1:0]   shifted;

    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [TAG_W-1:0]   tag_q;

    // Stage input: the request port for stage 0, the previous register otherwise.
    if (s == 0) begin : g_src_in
      assign src_valid = in_valid && in_ready;
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_mode  = in_mode;
      assign src_sign  = in_data[WIDTH-1];
      assign src_tag   = in_tag;
    end else begin : g_src_prev
      assign src_valid = g_stage[s-1].valid_q;
      assign src_data  = g_stage[s-1].data_q;
      assign src_shamt = g_stage[s-1].g_ctrl.shamt_q;
      assign src_mode  = g_stage[s-1].g_ctrl.mode_q;
      assign src_sign  = g_stage[s-1].g_ctrl.sign_q;
      assign src_tag   = g_stage[s-1].tag_q;
    end

    // Readiness propagates backwards from the consumer.
    if (s == STAGES - 1) begin : g_rdy_out
      assign next_ready = out_ready;
    end else begin : g_rdy_next
      assign next_ready = g_stage[s+1].ready;
    end

    assign ready = !valid_q || next_ready;
    assign load  = src_valid && ready && !flush;

    // Levels assigned to this stage, applied in ascending order.
    always_comb begin
      shifted = src_data;
      for (int unsigned i = 0; i < SHAMT_W; i++) begin
        if ((stage_of(i) == S) && (|(src_shamt & (SHAMT_W'(1) << i)))) begin
          shifted = shift_level(shifted, src_mode, src_sign, i);
        end
      end
    end

    // Occupancy: flush empties the stage, otherwise it follows upstream when ready.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (ready) begin
        valid_q <= src_valid;
      end
    end

    // Payload only moves with a real operation so a stalled result stays put.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        tag_q  <= '0;
      end else if (load) begin
        data_q <= shifted;
        tag_q  <= src_tag;
      end
    end

    // Control travels with the data only where a later stage still needs it.
    if (s < STAGES - 1) begin : g_ctrl
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         mode_q;
      logic               sign_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shamt_q <= '0;
          mode_q  <= '0;
          sign_q  <= 1'b0;
        end else if (load) begin
          shamt_q <= src_shamt;
          mode_q  <= src_mode;
          sign_q  <= src_sign;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ready && !flush;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_data  = g_stage[STAGES-1].data_q;
  assign out_tag   = g_stage[STAGES-1].tag_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed vectors on a 32-bit/2-stage instance plus
// a sweep of three other parameter sets against a bit-level reference model.
// Stimulus pushes expected results into per-instance queues; independent
// monitors pop and compare whenever an instance presents a result.

module tb_pipe_shifter;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
    int          lat;
  } exp_t;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] ROTR = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Main instance: WIDTH=32, STAGES=2
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_mode = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  // Sweep instances
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid;
  logic [7:0]  a_in_data = '0, a_out_data;
  logic [2:0]  a_in_shamt = '0;
  logic [1:0]  a_in_mode = '0;
  logic [4:0]  a_in_tag = '0, a_out_tag;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic [7:0]  b_in_data = '0, b_out_data;
  logic [2:0]  b_in_shamt = '0;
  logic [1:0]  b_in_mode = '0;
  logic [4:0]  b_in_tag = '0, b_out_tag;

  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid;
  logic [63:0] c_in_data = '0, c_out_data;
  logic [5:0]  c_in_shamt = '0;
  logic [1:0]  c_in_mode = '0;
  logic [4:0]  c_in_tag = '0, c_out_tag;

  exp_t q_main[$];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t em, ea, eb, ec;

  pipe_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  pipe_shifter #(.WIDTH(8), .STAGES(1), .TAG_W(5)) u_w8s1 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(1'b1), .out_data(a_out_data), .out_tag(a_out_tag)
  );

  pipe_shifter #(.WIDTH(8), .STAGES(3), .TAG_W(5)) u_w8s3 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  pipe_shifter #(.WIDTH(64), .STAGES(6), .TAG_W(5)) u_w64s6 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_shamt(c_in_shamt), .in_mode(c_in_mode), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out_data), .out_tag(c_out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual still running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Bit-by-bit reference, written independently of any level decomposition.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w, input int sh,
                                            input logic [1:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < w; b++) begin
      case (m)
        SLL:     r[b] = (b - sh >= 0) ? d[b-sh] : 1'b0;
        SRL:     r[b] = (b + sh < w) ? d[b+sh] : 1'b0;
        SRA:     r[b] = (b + sh < w) ? d[b+sh] : d[w-1];
        default: r[b] = d[(b+sh)%w];
      endcase
    end
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] d, input logic [4:0] t, input int lat);
    exp_t e;
    e.data = d;
    e.tag  = t;
    e.cyc  = cyc;
    e.lat  = lat;
    return e;
  endfunction

  // Present one request on the main instance; caller is just after a rising edge.
  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                       input logic [4:0] t, input logic [31:0] req, input bit push, input int lat);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("issue accept timeout", 64'(in_ready), 64'd1);
    else if (push) q_main.push_back(mk_exp(64'(req), t, lat));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_main.size() + q_a.size() + q_b.size() + q_c.size()) != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 64'(q_main.size() + q_a.size() + q_b.size() + q_c.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (q_main.size() == 0) check("main spurious output", 64'(out_tag), 64'h1f_dead);
      else begin
        em = q_main.pop_front();
        check("main data", 64'(out_data), em.data);
        check("main tag", 64'(out_tag), 64'(em.tag));
        if (em.lat >= 0) check("main latency", 64'(cyc - em.cyc), 64'(em.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && a_out_valid) begin
      if (q_a.size() == 0) check("w8s1 spurious output", 64'(a_out_tag), 64'h1f_dead);
      else begin
        ea = q_a.pop_front();
        check("w8s1 data", 64'(a_out_data), ea.data);
        check("w8s1 tag", 64'(a_out_tag), 64'(ea.tag));
        check("w8s1 latency", 64'(cyc - ea.cyc), 64'(ea.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_out_valid) begin
      if (q_b.size() == 0) check("w8s3 spurious output", 64'(b_out_tag), 64'h1f_dead);
      else begin
        eb = q_b.pop_front();
        check("w8s3 data", 64'(b_out_data), eb.data);
        check("w8s3 tag", 64'(b_out_tag), 64'(eb.tag));
        check("w8s3 latency", 64'(cyc - eb.cyc), 64'(eb.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && c_out_valid) begin
      if (q_c.size() == 0) check("w64s6 spurious output", 64'(c_out_tag), 64'h1f_dead);
      else begin
        ec = q_c.pop_front();
        check("w64s6 data", c_out_data, ec.data);
        check("w64s6 tag", 64'(c_out_tag), 64'(ec.tag));
        check("w64s6 latency", 64'(cyc - ec.cyc), 64'(ec.lat));
      end
    end
  end

  initial begin
    // Reset state
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Modes, back to back, full throughput
    issue(32'h0000_ABCD, 5'd16, SLL,  5'd1, 32'hABCD_0000, 1'b1, 2);
    issue(32'h8000_0001, 5'd31, SRL,  5'd2, 32'h0000_0001, 1'b1, 2);
    issue(32'h8000_0000, 5'd4,  SRA,  5'd3, 32'hF800_0000, 1'b1, 2);
    issue(32'h0000_0001, 5'd1,  ROTR, 5'd4, 32'h8000_0000, 1'b1, 2);
    issue(32'h7000_0000, 5'd4,  SRA,  5'd5, 32'h0700_0000, 1'b1, 2);
    issue(32'h1234_5678, 5'd8,  ROTR, 5'd6, 32'h7812_3456, 1'b1, 2);
    issue(32'hFFFF_FFFF, 5'd31, SLL,  5'd7, 32'h8000_0000, 1'b1, 2);
    issue(32'hF000_000F, 5'd31, SRA,  5'd8, 32'hFFFF_FFFF, 1'b1, 2);
    drain("modes drained");

    // Zero shift in every mode
    issue(32'hDEAD_BEEF, 5'd0, SLL,  5'd9,  32'hDEAD_BEEF, 1'b1, 2);
    issue(32'hDEAD_BEEF, 5'd0, SRL,  5'd10, 32'hDEAD_BEEF, 1'b1, 2);
    issue(32'hDEAD_BEEF, 5'd0, SRA,  5'd11, 32'hDEAD_BEEF, 1'b1, 2);
    issue(32'hDEAD_BEEF, 5'd0, ROTR, 5'd12, 32'hDEAD_BEEF, 1'b1, 2);
    drain("zero shift drained");

    // Backpressure: two fill the pipe, the rest wait, then all drain one per cycle
    out_ready = 1'b0;
    fork
      begin
        issue(32'h0000_0001, 5'd1,  SLL,  5'd13, 32'h0000_0002, 1'b1, -1);
        issue(32'h0000_0100, 5'd4,  SRL,  5'd14, 32'h0000_0010, 1'b1, -1);
        issue(32'h0000_000F, 5'd4,  ROTR, 5'd15, 32'hF000_0000, 1'b1, -1);
        issue(32'h8000_0000, 5'd31, SRA,  5'd16, 32'hFFFF_FFFF, 1'b1, -1);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("bp in_ready low when full", 64'(in_ready), 64'd0);
          check("bp out_valid held", 64'(out_valid), 64'd1);
          check("bp out_data stable", 64'(out_data), 64'h2);
          check("bp out_tag stable", 64'(out_tag), 64'd13);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("bp four results in four cycles", 64'(q_main.size()), 64'd0);
      end
    join
    @(posedge clk);
    #1;
    drain("backpressure drained");

    // Flush with two operations in flight and a request offered
    out_ready = 1'b0;
    issue(32'h0000_0011, 5'd1, SLL, 5'd17, 32'h0, 1'b0, -1);
    issue(32'h0000_0022, 5'd1, SLL, 5'd18, 32'h0, 1'b0, -1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0033;
    in_shamt = 5'd1;
    in_mode  = SLL;
    in_tag   = 5'd19;
    @(negedge clk);
    check("flush blocks in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid after flush", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    issue(32'h0000_0003, 5'd2, SLL, 5'd20, 32'h0000_000C, 1'b1, 2);
    drain("post-flush drained");

    // Asynchronous reset with two operations in flight
    out_ready = 1'b0;
    issue(32'h0000_0001, 5'd4, SLL, 5'd21, 32'h0, 1'b0, -1);
    issue(32'h0000_0002, 5'd4, SLL, 5'd22, 32'h0, 1'b0, -1);
    @(negedge clk);
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    check("pre-reset out_data", 64'(out_data), 64'h10);
    #2;
    reset = 1'b1;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_data", 64'(out_data), 64'd0);
    check("async reset out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready after mid reset", 64'(in_ready), 64'd1);
    check("out_valid after mid reset", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Parameter sweep against the reference model
    for (int k = 0; k < 40; k++) begin
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_in_data  = 8'($urandom);
      a_in_shamt = 3'($urandom);
      a_in_mode  = 2'($urandom);
      a_in_tag   = 5'($urandom);
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_data  = 8'($urandom);
      b_in_shamt = 3'($urandom);
      b_in_mode  = 2'($urandom);
      b_in_tag   = 5'($urandom);
      c_in_valid = ($urandom_range(0, 3) != 0);
      c_in_data  = {$urandom, $urandom};
      c_in_shamt = 6'($urandom);
      c_in_mode  = 2'($urandom);
      c_in_tag   = 5'($urandom);
      @(negedge clk);
      if (a_in_valid && a_in_ready)
        q_a.push_back(mk_exp(ref_shift(64'(a_in_data), 8, int'(a_in_shamt), a_in_mode), a_in_tag, 1));
      if (b_in_valid && b_in_ready)
        q_b.push_back(mk_exp(ref_shift(64'(b_in_data), 8, int'(b_in_shamt), b_in_mode), b_in_tag, 3));
      if (c_in_valid && c_in_ready)
        q_c.push_back(mk_exp(ref_shift(c_in_data, 64, int'(c_in_shamt), c_in_mode), c_in_tag, 6));
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    drain("sweep drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
